wave_sched: RTL and testbench

Sequencing controller for the sine-wave compute datapath. It divides `clk1` into a programmable sample-enable strobe and owns the datapath's reset. It holds the active amplitude, phase-offset and phase-increment registers, so that host parameter changes land only on sample boundaries. It sits between the host wire endpoints and the wave compute core, replacing the ad-hoc loop counter in the top level.

---
 rtl/wave_pkg.sv | 19 +
 rtl/wave_tick_div.sv | 51 +++++
 rtl/wave_sched.sv | 187 ++++++++++++++++++
 tb/tb_wave_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the sine-wave sequencing controller.
//   W_DEFAULT            : default datapath / parameter width
//   FLUSH_CYCLES_DEFAULT : default number of core_reset cycles after run start
//   wave_state_t         : controller state (IDLE, FLUSH, RUN)
// ---------------------------------------------------------------------------
package wave_pkg;

  localparam int W_DEFAULT            = 16;
  localparam int FLUSH_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } wave_state_t;

endpackage

// File: rtl/wave_tick_div.sv
// ---------------------------------------------------------------------------
// wave_tick_div
// Reloadable down-counter that produces the registered sample-enable strobe.
// The strobe is high during exactly the cycle in which the counter reads 0,
// so a divider value D gives one strobe every D+1 cycles (D=0: always high).
// Ports:
//   clk1      in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   enable    in   count while high; strobe forced low while low
//   load      in   load counter from divider (takes priority over enable)
//   divider   in   W  period minus one, sampled at every load/reload
//   sample_en out  registered one-cycle strobe
// ---------------------------------------------------------------------------
module wave_tick_div
  import wave_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk1,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] divider,
  output logic         sample_en
);

  logic [W-1:0] count;

  // The strobe is registered from the counter's next value, so it lines up
  // with the cycle in which the counter actually holds 0.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      sample_en <= 1'b0;
    end else if (load) begin
      count     <= divider;
      sample_en <= (divider == '0);
    end else if (enable) begin
      if (count == '0) begin
        count     <= divider;
        sample_en <= (divider == '0);
      end else begin
        count     <= count - W'(1);
        sample_en <= (count == W'(1));
      end
    end else begin
      sample_en <= 1'b0;
    end
  end

endmodule

// File: rtl/wave_sched.sv
// ---------------------------------------------------------------------------
// wave_sched
// Sequencing controller for the sine-wave compute core. Generates the
// sample-enable strobe, owns the core reset, and holds the active amplitude,
// phase-offset and phase-increment registers so host updates only land on
// sample boundaries.
// Optional feature macro: WAVE_SWEEP_EN (phase-increment sweep).
// Ports:
//   clk1            in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   run             in   level, 1 = generate samples
//   cfg_amp         in   W  host amplitude
//   cfg_phaseoffset in   W  host phase offset
//   cfg_phaseadd    in   W  host phase increment (sweep base when swept)
//   cfg_divider     in   W  sample period minus one
//   cfg_commit      in   level, each rising edge requests an update
//   cfg_sweep_step  in   W  sweep increment   (WAVE_SWEEP_EN only)
//   cfg_sweep_limit in   W  sweep upper bound (WAVE_SWEEP_EN only)
//   amp/phaseoffset/phaseadd out W  active parameters
//   sample_en       out  one-cycle clock enable to the core
//   core_reset      out  active-high reset to the core
//   commit_ack      out  pulse when an update takes effect
//   pending         out  update requested, not yet applied
//   sample_count    out  16  samples issued since last run start (wraps)
// ---------------------------------------------------------------------------
module wave_sched
  import wave_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int W            = W_DEFAULT
) (
  input  logic         clk1,
  input  logic         reset_n,
  input  logic         run,
  input  logic [W-1:0] cfg_amp,
  input  logic [W-1:0] cfg_phaseoffset,
  input  logic [W-1:0] cfg_phaseadd,
  input  logic [W-1:0] cfg_divider,
  input  logic         cfg_commit,
`ifdef WAVE_SWEEP_EN
  input  logic [W-1:0] cfg_sweep_step,
  input  logic [W-1:0] cfg_sweep_limit,
`endif
  output logic [W-1:0] amp,
  output logic [W-1:0] phaseoffset,
  output logic [W-1:0] phaseadd,
  output logic         sample_en,
  output logic         core_reset,
  output logic         commit_ack,
  output logic         pending,
  output logic [15:0]  sample_count
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  wave_state_t state;
  logic [7:0]  flush_cnt;
  logic        commit_d;
  logic        commit_edge;
  logic        in_flush;
  logic        in_run;
  logic        last_flush;
  logic        apply_commit;

  // Commit edge feeds the update logic combinationally so an edge that lands
  // on a sample boundary is applied on that same clock edge. Dropping run
  // wins over everything in FLUSH/RUN, hence the run qualifiers.
  always_comb begin
    commit_edge  = cfg_commit & ~commit_d;
    in_flush     = (state == FLUSH) && run;
    in_run       = (state == RUN) && run;
    last_flush   = in_flush && (flush_cnt == FLUSH_LAST);
    apply_commit = ((state == IDLE) && commit_edge) ||
                   (in_run && sample_en && (pending || commit_edge));
  end

  wave_tick_div #(.W(W)) u_tick_div (
    .clk1      (clk1),
    .reset_n   (reset_n),
    .enable    (in_run),
    .load      (last_flush),
    .divider   (cfg_divider),
    .sample_en (sample_en)
  );

  // Sequencing FSM: state, flush timing, core reset, pending flag and the
  // sample counter. sample_count is cleared on entry to FLUSH as well so it
  // reads 0 from the first cycle after a run start.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      commit_d     <= 1'b0;
      pending      <= 1'b0;
      core_reset   <= 1'b1;
      sample_count <= '0;
    end else begin
      commit_d <= cfg_commit;
      case (state)
        IDLE: begin
          core_reset <= 1'b1;
          pending    <= 1'b0;
          if (run) begin
            state        <= FLUSH;
            flush_cnt    <= '0;
            sample_count <= '0;
          end
        end
        FLUSH: begin
          if (!run) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else begin
            sample_count <= '0;
            if (commit_edge) pending <= 1'b1;
            if (flush_cnt == FLUSH_LAST) begin
              state      <= RUN;
              core_reset <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          if (!run) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            pending    <= 1'b0;
          end else begin
            if (sample_en) sample_count <= sample_count + 16'd1;
            if (apply_commit)     pending <= 1'b0;
            else if (commit_edge) pending <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          pending    <= 1'b0;
        end
      endcase
    end
  end

`ifdef WAVE_SWEEP_EN
  logic [W-1:0] phase_base;
  logic [W:0]   sweep_sum;
  logic [W-1:0] sweep_next;

  // Sweep wraps back to the committed base on carry-out or when the limit
  // is exceeded; a zero step leaves phaseadd unchanged.
  always_comb begin
    sweep_sum = {1'b0, phaseadd} + {1'b0, cfg_sweep_step};
    if (sweep_sum[W] || (sweep_sum[W-1:0] > cfg_sweep_limit)) sweep_next = phase_base;
    else                                                      sweep_next = sweep_sum[W-1:0];
  end
`endif

  // Active parameter registers. A commit always beats a sweep step on the
  // same edge.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      amp         <= '0;
      phaseoffset <= '0;
      phaseadd    <= '0;
      commit_ack  <= 1'b0;
`ifdef WAVE_SWEEP_EN
      phase_base  <= '0;
`endif
    end else begin
      commit_ack <= apply_commit;
      if (apply_commit) begin
        amp         <= cfg_amp;
        phaseoffset <= cfg_phaseoffset;
        phaseadd    <= cfg_phaseadd;
`ifdef WAVE_SWEEP_EN
        phase_base  <= cfg_phaseadd;
`endif
      end
`ifdef WAVE_SWEEP_EN
      else if (in_run && sample_en) begin
        phaseadd <= sweep_next;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wave_sched.sv
// ---------------------------------------------------------------------------
// tb_wave_sched
// Self-checking bench for wave_sched. Expected sample timing, counts and
// parameter values come from arithmetic on run-start-relative cycle indices.
// ---------------------------------------------------------------------------
module tb_wave_sched;

  localparam int W = 16;
  localparam int F = 4;

  logic         clk1 = 1'b0;
  logic         reset_n = 1'b1;
  logic         run;
  logic [W-1:0] cfg_amp, cfg_phaseoffset, cfg_phaseadd, cfg_divider;
  logic         cfg_commit;
`ifdef WAVE_SWEEP_EN
  logic [W-1:0] cfg_sweep_step, cfg_sweep_limit;
`endif
  logic [W-1:0] amp, phaseoffset, phaseadd;
  logic         sample_en, core_reset, commit_ack, pending;
  logic [15:0]  sample_count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] e_amp, e_off, e_pa;

  wave_sched #(.FLUSH_CYCLES(F), .W(W)) dut (
    .clk1            (clk1),
    .reset_n         (reset_n),
    .run             (run),
    .cfg_amp         (cfg_amp),
    .cfg_phaseoffset (cfg_phaseoffset),
    .cfg_phaseadd    (cfg_phaseadd),
    .cfg_divider     (cfg_divider),
    .cfg_commit      (cfg_commit),
`ifdef WAVE_SWEEP_EN
    .cfg_sweep_step  (cfg_sweep_step),
    .cfg_sweep_limit (cfg_sweep_limit),
`endif
    .amp             (amp),
    .phaseoffset     (phaseoffset),
    .phaseadd        (phaseadd),
    .sample_en       (sample_en),
    .core_reset      (core_reset),
    .commit_ack      (commit_ack),
    .pending         (pending),
    .sample_count    (sample_count)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Cycle j = the cycle after the j-th clock edge counted from the edge that
  // samples run=1 in IDLE. Flush occupies cycles 0..F-1; the first sample is
  // d+1 cycles after the last flush cycle, then every d+1 cycles.
  function automatic bit se_exp(input int j, input int d);
    if (j < F + d) return 1'b0;
    return ((j - F - d) % (d + 1)) == 0;
  endfunction

  function automatic int cnt_exp(input int j, input int d);
    if (j <= F + d) return 0;
    return (j - 1 - F - d) / (d + 1) + 1;
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic start_run(input int d);
    cfg_divider = 16'(d);
    run = 1'b1;
    tick();
  endtask

  task automatic stop_run();
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    run = 1'b0;
    cfg_commit = 1'b0;
    cfg_amp = 16'($urandom);
    cfg_phaseoffset = 16'($urandom);
    cfg_phaseadd = 16'($urandom);
    cfg_divider = 16'($urandom);
`ifdef WAVE_SWEEP_EN
    cfg_sweep_step = '0;
    cfg_sweep_limit = 16'hFFFF;
`endif
    #2 reset_n = 1'b0;
    #10;
    checks++; if ({amp, phaseoffset, phaseadd} !== 48'h0) begin errors++;
      $display("[TB] FAIL reset_params: got %h expected 0", {amp, phaseoffset, phaseadd}); end
    checks++; if (core_reset !== 1'b1) begin errors++;
      $display("[TB] FAIL reset_core_reset: got %b expected 1", core_reset); end
    checks++; if ({sample_en, commit_ack, pending} !== 3'b000) begin errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 000", {sample_en, commit_ack, pending}); end
    checks++; if (sample_count !== 16'h0) begin errors++;
      $display("[TB] FAIL reset_count: got %h expected 0", sample_count); end
    reset_n = 1'b1;
    tick();
    checks++; if ({core_reset, sample_en, commit_ack} !== 3'b100) begin errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 100", {core_reset, sample_en, commit_ack}); end
    e_amp = '0; e_off = '0; e_pa = '0;
  endtask

  task automatic test_idle_commit();
    logic [W-1:0] a, o, p;
    a = 16'($urandom); o = 16'($urandom); p = 16'($urandom);
    cfg_amp = a; cfg_phaseoffset = o; cfg_phaseadd = p;
    cfg_commit = 1'b1;
    tick();
    checks++; if ({amp, phaseoffset, phaseadd} !== {a, o, p}) begin errors++;
      $display("[TB] FAIL idle_commit_params: got %h expected %h", {amp, phaseoffset, phaseadd}, {a, o, p}); end
    checks++; if ({commit_ack, pending} !== 2'b10) begin errors++;
      $display("[TB] FAIL idle_commit_ack: got %b expected 10", {commit_ack, pending}); end
    cfg_amp = ~a; cfg_phaseoffset = ~o; cfg_phaseadd = ~p;
    tick();
    checks++; if (commit_ack !== 1'b0) begin errors++;
      $display("[TB] FAIL idle_commit_held_ack: got %b expected 0", commit_ack); end
    checks++; if ({amp, phaseoffset, phaseadd} !== {a, o, p}) begin errors++;
      $display("[TB] FAIL idle_commit_held_params: got %h expected %h", {amp, phaseoffset, phaseadd}, {a, o, p}); end
    cfg_commit = 1'b0;
    tick();
    e_amp = a; e_off = o; e_pa = p;
  endtask

  task automatic test_start(input int d);
    start_run(d);
    for (int j = 0; j <= F + d + 3 * (d + 1) + 2; j++) begin
      if (j > 0) tick();
      checks++; if (sample_en !== se_exp(j, d)) begin errors++;
        $display("[TB] FAIL start_sample_en d=%0d j=%0d: got %b expected %b", d, j, sample_en, se_exp(j, d)); end
      checks++; if (core_reset !== (j < F)) begin errors++;
        $display("[TB] FAIL start_core_reset d=%0d j=%0d: got %b expected %b", d, j, core_reset, (j < F)); end
      checks++; if (sample_count !== 16'(cnt_exp(j, d))) begin errors++;
        $display("[TB] FAIL start_count d=%0d j=%0d: got %0d expected %0d", d, j, sample_count, cnt_exp(j, d)); end
    end
    stop_run();
    checks++; if ({core_reset, sample_en} !== 2'b10) begin errors++;
      $display("[TB] FAIL start_stop: got %b expected 10", {core_reset, sample_en}); end
  endtask

  task automatic test_commit(input int d, input logic [W-1:0] new_pa, input bit coincide, input bit late_change);
    int base, jc, m;
    logic [W-1:0] a1, o1, a2, o2, p2, fa, fo, fp;
    logic [3*W-1:0] exp_par;
    a1 = 16'($urandom); o1 = 16'($urandom);
    a2 = 16'($urandom); o2 = 16'($urandom); p2 = 16'($urandom);
    base = F + d + (d + 1) * int'($urandom_range(1, 2));
    if (coincide) begin
      jc = base; m = base;
    end else begin
      jc = base + 1 + int'($urandom_range(0, d - 1)); m = base + d + 1;
    end
    if (late_change && m > jc) begin fa = a2; fo = o2; fp = p2; end
    else begin fa = a1; fo = o1; fp = new_pa; end
    start_run(d);
    for (int j = 0; j <= m + 3; j++) begin
      if (j > 0) tick();
      exp_par = (j > m) ? {fa, fo, fp} : {e_amp, e_off, e_pa};
      checks++; if (pending !== (j >= jc + 1 && j <= m)) begin errors++;
        $display("[TB] FAIL commit_pending j=%0d: got %b expected %b", j, pending, (j >= jc + 1 && j <= m)); end
      checks++; if (commit_ack !== (j == m + 1)) begin errors++;
        $display("[TB] FAIL commit_ack j=%0d: got %b expected %b", j, commit_ack, (j == m + 1)); end
      checks++; if ({amp, phaseoffset, phaseadd} !== exp_par) begin errors++;
        $display("[TB] FAIL commit_params j=%0d: got %h expected %h", j, {amp, phaseoffset, phaseadd}, exp_par); end
      checks++; if (sample_en !== se_exp(j, d)) begin errors++;
        $display("[TB] FAIL commit_sample_en j=%0d: got %b expected %b", j, sample_en, se_exp(j, d)); end
      if (j == jc) begin
        cfg_amp = a1; cfg_phaseoffset = o1; cfg_phaseadd = new_pa; cfg_commit = 1'b1;
      end
      if (j == jc + 1 && late_change && m > jc) begin
        cfg_amp = a2; cfg_phaseoffset = o2; cfg_phaseadd = p2;
      end
      if (j == jc + 1 && m >= jc + 2) cfg_commit = 1'b0;
      if (j == jc + 2 && m >= jc + 2) cfg_commit = 1'b1;
      if (j == m + 2) cfg_commit = 1'b0;
    end
    stop_run();
    e_amp = fa; e_off = fo; e_pa = fp;
  endtask

  task automatic test_run_drop();
    int d, jc, jd;
    d = int'($urandom_range(4, 8));
    jc = F + d + 1;
    jd = jc + 2;
    start_run(d);
    for (int j = 1; j <= jd; j++) begin
      tick();
      if (j == jc) begin
        cfg_amp = ~e_amp; cfg_phaseoffset = ~e_off; cfg_phaseadd = ~e_pa; cfg_commit = 1'b1;
      end
    end
    checks++; if (pending !== 1'b1) begin errors++;
      $display("[TB] FAIL drop_pending_before: got %b expected 1", pending); end
    stop_run();
    checks++; if ({pending, sample_en, core_reset, commit_ack} !== 4'b0010) begin errors++;
      $display("[TB] FAIL drop_outputs: got %b expected 0010", {pending, sample_en, core_reset, commit_ack}); end
    checks++; if ({amp, phaseoffset, phaseadd} !== {e_amp, e_off, e_pa}) begin errors++;
      $display("[TB] FAIL drop_params: got %h expected %h", {amp, phaseoffset, phaseadd}, {e_amp, e_off, e_pa}); end
    cfg_commit = 1'b0;
    tick();
    checks++; if ({pending, core_reset, commit_ack} !== 3'b010) begin errors++;
      $display("[TB] FAIL drop_idle: got %b expected 010", {pending, core_reset, commit_ack}); end

    start_run(d);
    for (int j = 1; j <= jd; j++) begin
      tick();
      if (j == jc) begin
        cfg_amp = ~e_amp; cfg_phaseoffset = ~e_off; cfg_phaseadd = ~e_pa; cfg_commit = 1'b1;
      end
    end
    checks++; if ({pending, core_reset} !== 2'b10) begin errors++;
      $display("[TB] FAIL areset_before: got %b expected 10", {pending, core_reset}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({pending, sample_en, core_reset, commit_ack} !== 4'b0010) begin errors++;
      $display("[TB] FAIL areset_outputs: got %b expected 0010", {pending, sample_en, core_reset, commit_ack}); end
    checks++; if ({amp, phaseoffset, phaseadd, sample_count} !== 64'h0) begin errors++;
      $display("[TB] FAIL areset_regs: got %h expected 0", {amp, phaseoffset, phaseadd, sample_count}); end
    run = 1'b0;
    cfg_commit = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    checks++; if ({core_reset, sample_en} !== 2'b10) begin errors++;
      $display("[TB] FAIL areset_idle: got %b expected 10", {core_reset, sample_en}); end
    e_amp = '0; e_off = '0; e_pa = '0;
  endtask

  task automatic test_div0();
    start_run(0);
    for (int j = 0; j <= F + 65536; j++) begin
      if (j > 0) tick();
      checks++; if (sample_en !== (j >= F)) begin errors++;
        $display("[TB] FAIL div0_sample_en j=%0d: got %b expected %b", j, sample_en, (j >= F)); end
      if (j == F || j == F + 1 || j == F + 65535 || j == F + 65536) begin
        checks++; if (sample_count !== 16'(cnt_exp(j, 0))) begin errors++;
          $display("[TB] FAIL div0_count j=%0d: got %h expected %h", j, sample_count, 16'(cnt_exp(j, 0))); end
      end
    end
    stop_run();
  endtask

`ifdef WAVE_SWEEP_EN
  function automatic logic [W-1:0] sweep_model(input logic [W-1:0] base, step, limit, input int n);
    logic [W-1:0] v;
    int s;
    v = base;
    for (int i = 0; i < n; i++) begin
      s = int'(v) + int'(step);
      if (s > 65535 || s > int'(limit)) v = base;
      else v = 16'(s);
    end
    return v;
  endfunction

  task automatic test_sweep(input logic [W-1:0] base, step, limit, input int d);
    logic [W-1:0] ev;
    cfg_sweep_step = step;
    cfg_sweep_limit = limit;
    cfg_phaseadd = base;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    checks++; if (phaseadd !== base) begin errors++;
      $display("[TB] FAIL sweep_base: got %h expected %h", phaseadd, base); end
    tick();
    start_run(d);
    for (int j = 0; j <= F + d + 6 * (d + 1); j++) begin
      if (j > 0) tick();
      ev = sweep_model(base, step, limit, cnt_exp(j, d));
      checks++; if (phaseadd !== ev) begin errors++;
        $display("[TB] FAIL sweep_phaseadd j=%0d: got %h expected %h", j, phaseadd, ev); end
    end
    stop_run();
    cfg_sweep_step = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_commit();
    test_start(3);
    test_start(int'($urandom_range(1, 6)));
    test_commit(7, 16'h0100, 1'b0, 1'b0);
    test_commit(int'($urandom_range(2, 6)), 16'($urandom), 1'b1, 1'b0);
    test_commit(int'($urandom_range(3, 8)), 16'($urandom), 1'b0, 1'b1);
    test_run_drop();
    test_div0();
`ifdef WAVE_SWEEP_EN
    test_sweep(16'h0010, 16'h0010, 16'h0030, int'($urandom_range(0, 3)));
    test_sweep(16'($urandom_range(0, 16'h0FFF)), 16'($urandom_range(1, 16'h3000)),
               16'($urandom_range(16'h2000, 16'hFFFF)), int'($urandom_range(0, 2)));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
